// File: rtl/ascon_feeder.sv
// ascon_feeder: feeds ascon_top with start/key strobes, then AAD and message blocks cut from a 128-bit stream; captures the tag
module ascon_feeder #(
    parameter int LEN_W       = 16,
    parameter int START_CYC   = 5,
    parameter int TIMEOUT_CYC = 10000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_aad_len,
    input  logic [LEN_W-1:0] cmd_msg_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_data,
    output logic             core_start,
    output logic             core_key_valid,
    output logic             core_valid_data_in,
    output logic             core_last_block,
    output logic             core_eot,
    output logic [127:0]     core_data_in,
    output logic [4:0]       core_valid_bytes,
    input  logic             core_ready_for_data,
    input  logic             core_ready_tag,
    input  logic             core_done,
    input  logic [63:0]      core_tag1,
    input  logic [63:0]      core_tag2,
    output logic [127:0]     tag,
    output logic             tag_valid,
    output logic             busy,
    output logic             txn_done,
    output logic             err
);
    localparam int SC_W = $clog2(START_CYC + 1);
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {IDLE, START, AAD, MSG, WAIT_DONE} state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] aad_rem_q, msg_rem_q, rem;
    logic [SC_W-1:0]  sc_q;
    logic [WD_W-1:0]  wd_q;
    logic             tag_got_q;
    logic [4:0]       n;
    logic [127:0]     mask;
    logic             in_blk, empty, last, timeout, abort, done_ok, go, cap;

    // go is the issue handshake; an aborting cycle never issues a block
    always_comb begin
        in_blk  = state_q == AAD || state_q == MSG;
        rem     = state_q == AAD ? aad_rem_q : msg_rem_q;
        n       = rem > LEN_W'(16) ? 5'd16 : rem[4:0];
        last    = rem <= LEN_W'(16);
        empty   = state_q == MSG && msg_rem_q == '0;
        timeout = state_q != IDLE && wd_q == WD_W'(TIMEOUT_CYC - 1);
        abort   = timeout || (core_done && (state_q == START || in_blk));
        done_ok = state_q == WAIT_DONE && core_done && !timeout;
        go      = in_blk && core_ready_for_data && !core_valid_data_in && !abort && (in_valid || empty);
        cap     = state_q != IDLE && core_ready_tag && !tag_got_q;
        mask    = ~({128{1'b1}} >> {n, 3'b000});
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      state_d = cmd_valid ? START : IDLE;
            START:     state_d = sc_q == SC_W'(START_CYC - 1) ? (aad_rem_q != '0 ? AAD : MSG) : START;
            AAD:       state_d = go && last ? MSG : AAD;
            MSG:       state_d = go && last ? WAIT_DONE : MSG;
            WAIT_DONE: state_d = WAIT_DONE;
            default:   state_d = IDLE;
        endcase
        if (abort || done_ok) state_d = IDLE;
    end

    always_comb begin
        cmd_ready      = state_q == IDLE;
        busy           = state_q != IDLE;
        core_start     = state_q == START;
        core_key_valid = state_q == START;
        in_ready       = go && !empty;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            aad_rem_q          <= '0;
            msg_rem_q          <= '0;
            sc_q               <= '0;
            wd_q               <= '0;
            tag_got_q          <= 1'b0;
            tag                <= '0;
            tag_valid          <= 1'b0;
            txn_done           <= 1'b0;
            err                <= 1'b0;
            core_valid_data_in <= 1'b0;
            core_last_block    <= 1'b0;
            core_eot           <= 1'b0;
            core_valid_bytes   <= '0;
            core_data_in       <= '0;
        end else begin
            sc_q <= state_q == START ? sc_q + SC_W'(1) : '0;
            wd_q <= state_q == IDLE ? '0 : wd_q + WD_W'(1);
            if (state_q == IDLE && cmd_valid) begin
                aad_rem_q <= cmd_aad_len;
                msg_rem_q <= cmd_msg_len;
                tag_got_q <= 1'b0;
            end
            if (go && state_q == AAD) aad_rem_q <= aad_rem_q - LEN_W'(n);
            if (go && state_q == MSG) msg_rem_q <= msg_rem_q - LEN_W'(n);
            if (cap) begin
                tag       <= {core_tag1, core_tag2};
                tag_got_q <= 1'b1;
            end
            tag_valid          <= cap;
            txn_done           <= done_ok;
            err                <= abort;
            core_valid_data_in <= go;
            core_last_block    <= go && state_q == AAD && last;
            core_eot           <= go && state_q == MSG && last;
            core_valid_bytes   <= go ? n : 5'd0;
            core_data_in       <= go ? (in_data & mask) : '0;
        end
    end
endmodule

// File: tb/tb_ascon_feeder.sv
// tb_ascon_feeder: randomized self-checking bench for ascon_feeder against a block-plan reference model
module tb_ascon_feeder;
    localparam int SC = 5;
    localparam int TO = 50;
    localparam int NONE = 9999;

    logic         clk = 0, reset_n = 0, cmd_valid = 0, in_valid = 0;
    logic [15:0]  cmd_aad_len = 0, cmd_msg_len = 0;
    logic [127:0] in_data = 0;
    logic         core_ready_for_data = 0, core_ready_tag = 0, core_done = 0;
    logic [63:0]  core_tag1 = 0, core_tag2 = 0;
    logic         cmd_ready, in_ready, core_start, core_key_valid, core_valid_data_in;
    logic         core_last_block, core_eot, tag_valid, busy, txn_done, err;
    logic [127:0] core_data_in, tag;
    logic [4:0]   core_valid_bytes;

    always #5 clk = ~clk;

    ascon_feeder #(.LEN_W(16), .START_CYC(SC), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_aad_len(cmd_aad_len), .cmd_msg_len(cmd_msg_len), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .core_start(core_start),
        .core_key_valid(core_key_valid), .core_valid_data_in(core_valid_data_in),
        .core_last_block(core_last_block), .core_eot(core_eot), .core_data_in(core_data_in),
        .core_valid_bytes(core_valid_bytes), .core_ready_for_data(core_ready_for_data),
        .core_ready_tag(core_ready_tag), .core_done(core_done), .core_tag1(core_tag1),
        .core_tag2(core_tag2), .tag(tag), .tag_valid(tag_valid), .busy(busy),
        .txn_done(txn_done), .err(err)
    );

    int total = 0, bad = 0;
    int n_start, j_first_start, j_first_blk, b2b, viol, n_ir, n_tv, j_done, j_err;
    logic         accepted, end_cr, end_busy;
    logic [12:0]  snap;
    logic [127:0] snap_tag, tag_exp, tag_seen;
    logic [4:0]   q_vb[$], e_vb[$];
    logic         q_last[$], q_eot[$], e_last[$], e_eot[$];
    logic [127:0] q_data[$], q_words[$], e_data[$];

    // expected block list: AAD split into 16-byte chunks, then message chunks (or one empty block)
    task automatic plan(input int aad, input int msg);
        int r, c, w;
        logic [127:0] d;
        e_vb.delete(); e_last.delete(); e_eot.delete(); e_data.delete();
        w = 0;
        r = aad;
        while (r > 0) begin
            c = r > 16 ? 16 : r;
            e_vb.push_back(5'(c)); e_last.push_back(c == r); e_eot.push_back(1'b0);
            r -= c;
        end
        r = msg;
        do begin
            c = r > 16 ? 16 : r;
            e_vb.push_back(5'(c)); e_last.push_back(1'b0); e_eot.push_back(c == r);
            r -= c;
        end while (r > 0);
        foreach (e_vb[i]) begin
            d = '0;
            if (e_vb[i] != 0) begin
                d = w < q_words.size() ? q_words[w] : 'x;
                w++;
                for (int b = int'(e_vb[i]); b < 16; b++) d[127-8*b -: 8] = 8'h00;
            end
            e_data.push_back(d);
        end
    endtask

    // drives one command and records what the core side sees; j counts samples after the accept edge
    task automatic run_txn(input int aad, input int msg, input int pv, input int pr,
                           input int done_at, input int rst_at, input int max_j);
        logic prev_v = 0, eot_seen = 0;
        int since = 0;
        q_vb.delete(); q_last.delete(); q_eot.delete(); q_data.delete(); q_words.delete();
        n_start = 0; j_first_start = -1; j_first_blk = -1; b2b = 0; viol = 0;
        n_ir = 0; n_tv = 0; j_done = -1; j_err = -1;
        snap = 'x; snap_tag = 'x; tag_seen = 'x; end_cr = 'x; end_busy = 'x;
        @(negedge clk);
        cmd_valid = 1; cmd_aad_len = 16'(aad); cmd_msg_len = 16'(msg);
        accepted = cmd_ready;
        tag_exp = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk);
        for (int j = 0; j < max_j; j++) begin
            @(negedge clk);
            if (core_start && core_key_valid) begin
                n_start++;
                if (j_first_start < 0) j_first_start = j;
            end
            if (core_valid_data_in) begin
                q_vb.push_back(core_valid_bytes); q_last.push_back(core_last_block);
                q_eot.push_back(core_eot); q_data.push_back(core_data_in);
                if (prev_v) b2b++;
                if (j_first_blk < 0) j_first_blk = j;
                if (core_eot) eot_seen = 1;
            end
            prev_v = core_valid_data_in;
            if (tag_valid) begin n_tv++; tag_seen = tag; end
            if (txn_done && j_done < 0) j_done = j;
            if (err && j_err < 0) j_err = j;
            if (txn_done || err || j == rst_at + 1) begin
                snap = {cmd_ready, busy, core_start, core_key_valid, in_ready, core_valid_data_in,
                        core_last_block, core_eot, |core_data_in, |core_valid_bytes, tag_valid, txn_done, err};
                snap_tag = tag; end_cr = cmd_ready; end_busy = busy;
                break;
            end
            reset_n = j != rst_at;
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_aad_len = 16'($urandom); cmd_msg_len = 16'($urandom);
            in_valid = j >= 20 || int'($urandom_range(1, 100)) <= pv;
            in_data = {$urandom, $urandom, $urandom, $urandom};
            core_ready_for_data = j >= 20 || int'($urandom_range(1, 100)) <= pr;
            since = eot_seen ? since + 1 : 0;
            core_ready_tag = since == 1 || since == 2;
            {core_tag1, core_tag2} = since == 1 ? tag_exp : {$urandom, $urandom, $urandom, $urandom};
            core_done = done_at < 0 ? since == 3 : (done_at > 0 && j == done_at);
            #1;
            if (in_ready) begin
                n_ir++;
                q_words.push_back(in_data);
                if (!in_valid || !core_ready_for_data) viol++;
            end
        end
        cmd_valid = 0; in_valid = 0; core_ready_for_data = 0; core_ready_tag = 0; core_done = 0; reset_n = 1;
    endtask

    task automatic test_reset();
        reset_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({cmd_ready, busy, core_start, core_key_valid, in_ready, core_valid_data_in, core_last_block, core_eot,
             |core_data_in, |core_valid_bytes, tag_valid, txn_done, err} !== 13'h1000) begin
            bad++; $display("FAIL reset_outputs got=%b exp=%b", {cmd_ready, busy, core_start, core_key_valid, in_ready,
                core_valid_data_in, core_last_block, core_eot, |core_data_in, |core_valid_bytes, tag_valid, txn_done, err}, 13'h1000);
        end
        total++;
        if (tag !== '0) begin bad++; $display("FAIL reset_tag got=%h exp=0", tag); end
        reset_n = 1;
    endtask

    task automatic test_basic();
        run_txn(32, 20, 100, 100, -1, NONE, 60);
        plan(32, 20);
        total++;
        if (accepted !== 1'b1) begin bad++; $display("FAIL basic_accept got=%b exp=1", accepted); end
        total++;
        if (n_start !== SC || j_first_start !== 0) begin
            bad++; $display("FAIL basic_start got=%0d@%0d exp=%0d@0", n_start, j_first_start, SC);
        end
        total++;
        if (j_first_blk !== SC + 1) begin bad++; $display("FAIL basic_first_blk got=%0d exp=%0d", j_first_blk, SC + 1); end
        total++;
        if (j_done !== 15 || j_err !== -1) begin bad++; $display("FAIL basic_done got=%0d err=%0d exp=15 err=-1", j_done, j_err); end
        total++;
        if (end_cr !== 1'b1) begin bad++; $display("FAIL basic_cmd_ready got=%b exp=1", end_cr); end
        total++;
        if (tag_seen !== tag_exp || n_tv !== 1) begin
            bad++; $display("FAIL basic_tag got=%h n=%0d exp=%h n=1", tag_seen, n_tv, tag_exp);
        end
        total++;
        if (q_vb.size() !== e_vb.size()) begin
            bad++; $display("FAIL basic_nblk got=%0d exp=%0d", q_vb.size(), e_vb.size());
        end else foreach (e_vb[i]) begin
            total++;
            if ({q_vb[i], q_last[i], q_eot[i], q_data[i]} !== {e_vb[i], e_last[i], e_eot[i], e_data[i]}) begin
                bad++; $display("FAIL basic_blk%0d got=%0d/%b/%b/%h exp=%0d/%b/%b/%h", i, q_vb[i], q_last[i], q_eot[i],
                    q_data[i], e_vb[i], e_last[i], e_eot[i], e_data[i]);
            end
        end
    endtask

    task automatic test_empty();
        for (int k = 0; k < 2; k++) begin
            run_txn(0, 0, k * 100, 100, -1, NONE, 40);
            total++;
            if (q_vb.size() !== 1) begin
                bad++; $display("FAIL empty_nblk got=%0d exp=1", q_vb.size());
            end else begin
                total++;
                if ({q_vb[0], q_last[0], q_eot[0], q_data[0]} !== {5'd0, 1'b0, 1'b1, 128'd0}) begin
                    bad++; $display("FAIL empty_blk got=%0d/%b/%b/%h exp=0/0/1/0", q_vb[0], q_last[0], q_eot[0], q_data[0]);
                end
            end
            total++;
            if (n_ir !== 0) begin bad++; $display("FAIL empty_in_ready got=%0d exp=0", n_ir); end
            total++;
            if (j_done < 0 || j_err >= 0) begin bad++; $display("FAIL empty_done got=%0d err=%0d", j_done, j_err); end
        end
    endtask

    task automatic test_gapped();
        run_txn(5, 16, 50, 50, -1, NONE, 60);
        plan(5, 16);
        total++;
        if (viol !== 0) begin bad++; $display("FAIL gap_issue_when_low got=%0d exp=0", viol); end
        total++;
        if (b2b !== 0) begin bad++; $display("FAIL gap_back_to_back got=%0d exp=0", b2b); end
        total++;
        if (n_ir !== 2) begin bad++; $display("FAIL gap_words got=%0d exp=2", n_ir); end
        total++;
        if (j_done < 0 || j_err >= 0) begin bad++; $display("FAIL gap_done got=%0d err=%0d", j_done, j_err); end
        total++;
        if (q_vb.size() !== 2) begin
            bad++; $display("FAIL gap_nblk got=%0d exp=2", q_vb.size());
        end else foreach (e_vb[i]) begin
            total++;
            if ({q_vb[i], q_last[i], q_eot[i], q_data[i]} !== {e_vb[i], e_last[i], e_eot[i], e_data[i]}) begin
                bad++; $display("FAIL gap_blk%0d got=%0d/%b/%b/%h exp=%0d/%b/%b/%h", i, q_vb[i], q_last[i], q_eot[i],
                    q_data[i], e_vb[i], e_last[i], e_eot[i], e_data[i]);
            end
        end
    endtask

    task automatic test_proto_err();
        run_txn(48, 16, 100, 100, 7, NONE, 60);
        total++;
        if (j_err !== 8 || j_done !== -1) begin bad++; $display("FAIL proto_err got=%0d done=%0d exp=8 done=-1", j_err, j_done); end
        total++;
        if ({end_cr, end_busy} !== 2'b10) begin bad++; $display("FAIL proto_idle got=%b exp=10", {end_cr, end_busy}); end
    endtask

    task automatic test_timeout();
        run_txn(16, 16, 100, 100, 0, NONE, 80);
        total++;
        if (j_err !== TO || j_done !== -1) begin bad++; $display("FAIL timeout_err got=%0d done=%0d exp=%0d done=-1", j_err, j_done, TO); end
        total++;
        if (end_cr !== 1'b1) begin bad++; $display("FAIL timeout_cmd_ready got=%b exp=1", end_cr); end
    endtask

    task automatic test_reset_mid();
        int aad, msg;
        run_txn(16, 64, 100, 100, -1, 9, 60);
        total++;
        if (snap !== 13'h1000) begin bad++; $display("FAIL rstmid_outputs got=%b exp=%b", snap, 13'h1000); end
        total++;
        if (snap_tag !== '0) begin bad++; $display("FAIL rstmid_tag got=%h exp=0", snap_tag); end
        total++;
        if (q_vb.size() !== 2) begin bad++; $display("FAIL rstmid_blocks got=%0d exp=2", q_vb.size()); end
        aad = $urandom_range(0, 40); msg = $urandom_range(1, 40);
        run_txn(aad, msg, 100, 100, -1, NONE, 60);
        plan(aad, msg);
        total++;
        if (j_done < 0 || j_err >= 0 || tag_seen !== tag_exp) begin
            bad++; $display("FAIL rstmid_next_done got=%0d err=%0d tag=%h exp tag=%h", j_done, j_err, tag_seen, tag_exp);
        end
        total++;
        if (q_vb.size() !== e_vb.size()) begin
            bad++; $display("FAIL rstmid_nblk got=%0d exp=%0d", q_vb.size(), e_vb.size());
        end else foreach (e_vb[i]) begin
            total++;
            if ({q_vb[i], q_last[i], q_eot[i], q_data[i]} !== {e_vb[i], e_last[i], e_eot[i], e_data[i]}) begin
                bad++; $display("FAIL rstmid_blk%0d got=%0d/%b/%b/%h exp=%0d/%b/%b/%h", i, q_vb[i], q_last[i], q_eot[i],
                    q_data[i], e_vb[i], e_last[i], e_eot[i], e_data[i]);
            end
        end
    endtask

    task automatic test_random();
        int aad, msg;
        for (int t = 0; t < 10; t++) begin
            aad = $urandom_range(0, 48); msg = $urandom_range(0, 48);
            run_txn(aad, msg, $urandom_range(30, 100), $urandom_range(30, 100), -1, NONE, 60);
            plan(aad, msg);
            total++;
            if (accepted !== 1'b1 || j_done < 0 || j_err >= 0) begin
                bad++; $display("FAIL rand%0d_done acc=%b got=%0d err=%0d", t, accepted, j_done, j_err);
            end
            total++;
            if (viol !== 0 || b2b !== 0) begin bad++; $display("FAIL rand%0d_handshake viol=%0d b2b=%0d exp=0", t, viol, b2b); end
            total++;
            if (tag_seen !== tag_exp || n_tv !== 1) begin
                bad++; $display("FAIL rand%0d_tag got=%h n=%0d exp=%h n=1", t, tag_seen, n_tv, tag_exp);
            end
            total++;
            if (q_vb.size() !== e_vb.size()) begin
                bad++; $display("FAIL rand%0d_nblk aad=%0d msg=%0d got=%0d exp=%0d", t, aad, msg, q_vb.size(), e_vb.size());
            end else foreach (e_vb[i]) begin
                total++;
                if ({q_vb[i], q_last[i], q_eot[i], q_data[i]} !== {e_vb[i], e_last[i], e_eot[i], e_data[i]}) begin
                    bad++; $display("FAIL rand%0d_blk%0d got=%0d/%b/%b/%h exp=%0d/%b/%b/%h", t, i, q_vb[i], q_last[i],
                        q_eot[i], q_data[i], e_vb[i], e_last[i], e_eot[i], e_data[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty();
        test_gapped();
        test_proto_err();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ascon_feeder.md
# ascon_feeder

Transaction sequencer that sits between an upstream 128-bit data stream and the `ascon_top` core block interface. It accepts a command carrying AAD and message byte lengths, then pulses the core start and key strobes. It cuts the upstream stream into AAD blocks and then message blocks, driving `valid_bytes`, `last_block` and `EOT` itself. Finally it captures the tag and reports completion, or reports a timeout or protocol error.

## Interface
- LEN_W, 16, width of byte-length fields and remaining-byte counters
- START_CYC, 5, cycles `core_start`/`core_key_valid` are held high
- TIMEOUT_CYC, 10000, watchdog limit in cycles from leaving IDLE to `core_done`
- clk  in  1  single clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_aad_len  in  LEN_W  AAD length in bytes
- cmd_msg_len  in  LEN_W  message length in bytes
- in_valid  in  1  upstream word valid
- in_ready  out  1  upstream word consumed this cycle
- in_data  in  128  16 bytes; byte 0 at [127:120]
- core_start, core_key_valid  out  1  start/key strobes to core
- core_valid_data_in  out  1  one-cycle block strobe
- core_last_block  out  1  final AAD block flag
- core_eot  out  1  final message block flag
- core_data_in  out  128  block data, unused bytes zeroed
- core_valid_bytes  out  5  valid byte count, 0..16
- core_ready_for_data, core_ready_tag, core_done  in  1  core status
- core_tag1, core_tag2  in  64  core tag halves
- tag  out  128  captured {core_tag1, core_tag2}
- tag_valid  out  1  one-cycle pulse on capture
- busy  out  1  state != IDLE
- txn_done  out  1  one-cycle success pulse
- err  out  1  one-cycle pulse on timeout or protocol error

## Operation
- States: IDLE, START, AAD, MSG, WAIT_DONE.
- IDLE: `cmd_ready`=1. On `cmd_valid`, latch `aad_rem`=`cmd_aad_len` and `msg_rem`=`cmd_msg_len`, clear the watchdog, and go to START.
- START: `core_start`=`core_key_valid`=1 for exactly START_CYC cycles. Then go to AAD if `aad_rem`≠0, otherwise to MSG.
- Issue condition, checked in AAD and MSG: `core_ready_for_data`=1 AND `in_valid`=1 AND no block was issued in the previous cycle.
  - When it holds, `in_ready`=1, combinational, that same cycle.
  - Chunk n = min(16, rem). Bytes n..15 of `in_data` are forced to 0.
  - `rem` decrements by n.
- AAD block: `core_last_block`=1 iff n==`aad_rem`. After the last AAD block, go to MSG.
- MSG block: `core_eot`=1 iff n==`msg_rem`. After that block, go to WAIT_DONE.
- `msg_rem`==0 on entry to MSG: issue one empty block with `valid_bytes`=0, `core_eot`=1 and data=0. Do not wait for `in_valid` and do not assert `in_ready`.
- `core_ready_tag`=1 in any non-IDLE state: latch `tag`={`core_tag1`,`core_tag2`} and pulse `tag_valid`. Only the first capture per transaction counts.
- WAIT_DONE on `core_done`: pulse `txn_done` and go to IDLE.
- `core_done` seen in START, AAD or MSG is a protocol error: pulse `err` and go to IDLE.
- Watchdog counts every non-IDLE cycle. Reaching TIMEOUT_CYC: pulse `err` and go to IDLE. Timeout beats `core_done` if both occur in the same cycle.
- `cmd_valid` outside IDLE is ignored; `cmd_ready`=0.

## Timing
- Reset, with `reset_n`=0 sampled on an edge: state=IDLE, counters=0, `tag`=0, all outputs 0 except `cmd_ready`=1. This includes reset in the middle of a transaction: no partial block and no pulse after reset.
- Core-side outputs are registered and appear the cycle after the issue handshake.
- `core_valid_data_in`, `core_last_block`, `core_eot`, `core_valid_bytes` and `core_data_in` are all valid together for exactly one cycle, then return to 0.
- Maximum rate is one block every 2 cycles.
- `cmd_valid` accepted at edge t: `core_start` is high for edges t+1..t+START_CYC. The first block can issue at edge t+START_CYC+1.
- `txn_done`/`err` assert the cycle after the triggering event. `cmd_ready` returns to 1 in that same cycle.
- Length arithmetic is unsigned LEN_W. `rem` never underflows because n ≤ rem.

## Test plan
- aad=32, msg=20, core always ready: the core sees 2 AAD blocks (16, 16; `last_block` on the 2nd), then 2 MSG blocks (16, 4; `eot` on the 2nd, bytes 4..15=0). `core_done` then gives `txn_done` and `tag` equals the injected {tag1,tag2}.
- aad=0, msg=0: START, then one block with `valid_bytes`=0, `eot`=1 and `in_ready` never high. Then `done` gives `txn_done`.
- aad=5, msg=16 with `core_ready_for_data` toggled and `in_valid` gapped: no block is issued while either is low, blocks are never back-to-back, and exactly 2 blocks are issued in total.
- `core_done` asserted during AAD with aad=48: `err` pulses, state returns to IDLE, no `txn_done`.
- TIMEOUT_CYC=50 with `core_done` never asserted: `err` pulses exactly 50 cycles after leaving IDLE, then `cmd_ready`=1.
- `reset_n`=0 for 1 cycle mid-MSG: all outputs return to reset values the next cycle, and a new command then completes normally.
